// File: rtl/knn_query_sequencer.sv
// Query front-end for the k-NN core: packs serial features, streams the sample ROM, captures result.
// Optional KNN_QSEQ_QCOUNT_EN adds a 16-bit wrapping count of completed queries (query_count).
module knn_query_sequencer #(
  parameter int unsigned FEATURE_NUM = 7,
  parameter int unsigned LEN         = 13,
  parameter int unsigned DATA_WIDE   = 1,
  parameter int unsigned COM_NUM     = 600,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned RESULT_LAT  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [LEN-1:0]                   feat_in,
  input  logic                             feat_valid,
  output logic                             feat_ready,
  output logic [LEN*FEATURE_NUM-1:0]       query_feature,
  output logic                             core_en,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [LEN*FEATURE_NUM+DATA_WIDE-1:0] rom_data,
  output logic [LEN*FEATURE_NUM+DATA_WIDE-1:0] train_data,
  output logic                             train_valid,
  input  logic [DATA_WIDE-1:0]             core_result,
  output logic [DATA_WIDE-1:0]             result,
  output logic                             result_valid,
  output logic                             busy
`ifdef KNN_QSEQ_QCOUNT_EN
  ,
  output logic [15:0]                      query_count
`endif
);

  localparam int unsigned FW = $clog2(FEATURE_NUM + 1);
  localparam int unsigned SW = $clog2(COM_NUM + 1);
  localparam int unsigned DW = $clog2(RESULT_LAT + 1);
  localparam int unsigned QW = LEN * FEATURE_NUM;

  localparam logic [FW-1:0]     FLast = FW'(FEATURE_NUM - 1);
  localparam logic [SW-1:0]     SLast = SW'(COM_NUM);
  localparam logic [DW-1:0]     DLast = DW'(RESULT_LAT);
  localparam logic [ADDR_W-1:0] ALast = ADDR_W'(COM_NUM - 1);

  typedef enum logic [2:0] {StCollect, StPrime, StStream, StDrain, StDone} state_e;

  state_e          state_q;
  logic [FW-1:0]   fcnt_q;
  logic [SW-1:0]   scnt_q;
  logic [DW-1:0]   dcnt_q;
  logic [QW-1:0]   slots_q;
  logic [QW-1:0]   slots_d;
  logic            accept;

  assign accept     = feat_valid && feat_ready;
  assign train_data = rom_data;

  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < FEATURE_NUM; i++) begin
      if (fcnt_q == FW'(i)) slots_d[LEN*i +: LEN] = feat_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StCollect;
      fcnt_q        <= '0;
      scnt_q        <= '0;
      dcnt_q        <= '0;
      slots_q       <= '0;
      query_feature <= '0;
      core_en       <= 1'b0;
      rom_addr      <= '0;
      train_valid   <= 1'b0;
      result        <= '0;
      result_valid  <= 1'b0;
      busy          <= 1'b0;
      feat_ready    <= 1'b1;
`ifdef KNN_QSEQ_QCOUNT_EN
      query_count   <= '0;
`endif
    end else begin
      case (state_q)
        StCollect: begin
          if (accept) begin
            if (fcnt_q == FLast) begin
              // Publish the full vector only once; partial slots stay internal.
              state_q       <= StPrime;
              fcnt_q        <= '0;
              slots_q       <= '0;
              query_feature <= slots_d;
              feat_ready    <= 1'b0;
              busy          <= 1'b1;
              core_en       <= 1'b1;
              rom_addr      <= '0;
            end else begin
              fcnt_q  <= fcnt_q + FW'(1);
              slots_q <= slots_d;
            end
          end
        end
        StPrime: begin
          state_q     <= StStream;
          train_valid <= 1'b1;
          scnt_q      <= SW'(1);
          rom_addr    <= rom_addr + ADDR_W'(1);
        end
        StStream: begin
          if (scnt_q == SLast) begin
            state_q     <= StDrain;
            train_valid <= 1'b0;
            dcnt_q      <= DW'(1);
          end else begin
            scnt_q <= scnt_q + SW'(1);
          end
          if (rom_addr != ALast) rom_addr <= rom_addr + ADDR_W'(1);
        end
        StDrain: begin
          if (dcnt_q == DLast) begin
            state_q      <= StDone;
            result       <= core_result;
            result_valid <= 1'b1;
`ifdef KNN_QSEQ_QCOUNT_EN
            query_count  <= query_count + 16'd1;
`endif
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        StDone: begin
          state_q       <= StCollect;
          result_valid  <= 1'b0;
          core_en       <= 1'b0;
          busy          <= 1'b0;
          feat_ready    <= 1'b1;
          query_feature <= '0;
        end
        default: state_q <= StCollect;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_query_sequencer.sv
// Directed self-checking bench for knn_query_sequencer (FEATURE_NUM=3, LEN=4, COM_NUM=4, RESULT_LAT=2).
module tb_knn_query_sequencer;

  localparam int unsigned FN = 3;
  localparam int unsigned L  = 4;
  localparam int unsigned DWD = 1;
  localparam int unsigned CN = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned RL = 2;

  logic          clk;
  logic          rst_n;
  logic [3:0]    feat_in;
  logic          feat_valid;
  logic          feat_ready;
  logic [11:0]   query_feature;
  logic          core_en;
  logic [9:0]    rom_addr;
  logic [12:0]   rom_data;
  logic [12:0]   train_data;
  logic          train_valid;
  logic [0:0]    core_result;
  logic [0:0]    result;
  logic          result_valid;
  logic          busy;
`ifdef KNN_QSEQ_QCOUNT_EN
  logic [15:0]   query_count;
`endif

  int checks = 0;
  int fails  = 0;

  knn_query_sequencer #(
    .FEATURE_NUM(FN), .LEN(L), .DATA_WIDE(DWD), .COM_NUM(CN), .ADDR_W(AW), .RESULT_LAT(RL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .feat_in      (feat_in),
    .feat_valid   (feat_valid),
    .feat_ready   (feat_ready),
    .query_feature(query_feature),
    .core_en      (core_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .train_data   (train_data),
    .train_valid  (train_valid),
    .core_result  (core_result),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy)
`ifdef KNN_QSEQ_QCOUNT_EN
    ,
    .query_count  (query_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] rom_word(input logic [9:0] a);
    logic [11:0] f;
    f = 12'h5A0 ^ {a[3:0], a[3:0], a[3:0]};
    return {f, a[0]};
  endfunction

  // One-cycle read latency library ROM.
  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_query(input logic [3:0] f0, input logic [3:0] f1, input logic [3:0] f2);
    feat_valid = 1'b1;
    feat_in = f0; tick;
    feat_in = f1; tick;
    feat_in = f2; tick;
    feat_valid = 1'b0;
    feat_in = 4'h0;
  endtask

  // Returns cycles waited after PRIME until result_valid, or -1 on timeout.
  task automatic wait_result(output int k);
    k = 0;
    while (!result_valid && k < 40) begin
      tick;
      k++;
    end
    if (!result_valid) k = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    checks++;
    if ({query_feature, core_en, rom_addr, train_valid, result, result_valid, busy, feat_ready}
        !== {12'h0, 1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got qf=%h en=%b addr=%0d tv=%b res=%b rv=%b busy=%b rdy=%b want 0,0,0,0,0,0,0,1",
               query_feature, core_en, rom_addr, train_valid, result, result_valid, busy, feat_ready);
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if ({feat_ready, busy} !== 2'b10) begin
      fails++;
      $display("FAIL post_reset_idle: got rdy=%b busy=%b want 1 0", feat_ready, busy);
    end
  endtask

  task automatic test_back_to_back;
    int exp_addr [7];
    exp_addr = '{0, 1, 2, 3, 3, 3, 3};
    core_result = 1'b1;
    feat_valid = 1'b1;
    feat_in = 4'h1; tick;
    feat_in = 4'h2; tick;
    checks++;
    if ({busy, query_feature} !== {1'b0, 12'h000}) begin
      fails++;
      $display("FAIL partial_hidden: got busy=%b qf=%h want 0 000", busy, query_feature);
    end
    feat_in = 4'h3; tick;
    feat_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 7) begin
        checks++;
        if (rom_addr !== 10'(exp_addr[k-1])) begin
          fails++;
          $display("FAIL rom_addr_k%0d: got %0d want %0d", k, rom_addr, exp_addr[k-1]);
        end
      end
      checks++;
      if (train_valid !== (k >= 2 && k <= 5)) begin
        fails++;
        $display("FAIL train_valid_k%0d: got %b want %b", k, train_valid, (k >= 2 && k <= 5));
      end
      if (k >= 2 && k <= 5) begin
        checks++;
        if (train_data !== rom_word(10'(k - 2))) begin
          fails++;
          $display("FAIL train_data_k%0d: got %h want %h", k, train_data, rom_word(10'(k - 2)));
        end
      end
      checks++;
      if (result_valid !== (k == 8)) begin
        fails++;
        $display("FAIL result_valid_k%0d: got %b want %b", k, result_valid, (k == 8));
      end
      if (k <= 8) begin
        checks++;
        if ({busy, feat_ready, core_en, query_feature} !== {1'b1, 1'b0, 1'b1, 12'h321}) begin
          fails++;
          $display("FAIL busy_hold_k%0d: got busy=%b rdy=%b en=%b qf=%h want 1 0 1 321",
                   k, busy, feat_ready, core_en, query_feature);
        end
      end
      if (k == 8) begin
        checks++;
        if (result !== 1'b1) begin
          fails++;
          $display("FAIL result_b2b: got %b want 1", result);
        end
      end
      if (k == 9) begin
        checks++;
        if ({busy, feat_ready, core_en, query_feature, result} !== {1'b0, 1'b1, 1'b0, 12'h000, 1'b1}) begin
          fails++;
          $display("FAIL back_to_collect: got busy=%b rdy=%b en=%b qf=%h res=%b want 0 1 0 000 1",
                   busy, feat_ready, core_en, query_feature, result);
        end
      end
      tick;
    end
  endtask

  task automatic test_hold_valid;
    int k;
    core_result = 1'b0;
    feat_valid = 1'b1;
    feat_in = 4'h5; tick;
    feat_in = 4'h6; tick;
    feat_in = 4'h7; tick;
    feat_in = 4'h8;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if ({feat_ready, query_feature} !== {1'b0, 12'h765}) begin
        fails++;
        $display("FAIL hold_busy_c%0d: got rdy=%b qf=%h want 0 765", c, feat_ready, query_feature);
      end
      if (c == 8) begin
        checks++;
        if ({result_valid, result} !== 2'b10) begin
          fails++;
          $display("FAIL hold_result: got rv=%b res=%b want 1 0", result_valid, result);
        end
      end
      tick;
    end
    checks++;
    if (feat_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_ready_after_done: got %b want 1", feat_ready);
    end
    tick;
    feat_in = 4'h9; tick;
    feat_in = 4'hA; tick;
    feat_valid = 1'b0;
    checks++;
    if ({busy, query_feature} !== {1'b1, 12'hA98}) begin
      fails++;
      $display("FAIL hold_next_query: got busy=%b qf=%h want 1 a98", busy, query_feature);
    end
    wait_result(k);
    checks++;
    if (k !== 7) begin
      fails++;
      $display("FAIL hold_latency: got %0d want 7", k);
    end
    tick;
  endtask

  task automatic test_gaps;
    logic       v [6];
    logic [3:0] d [6];
    int         k;
    v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    d = '{4'h1, 4'hF, 4'hF, 4'h2, 4'hF, 4'h3};
    core_result = 1'b1;
    for (int i = 0; i < 6; i++) begin
      feat_valid = v[i];
      feat_in = d[i];
      tick;
      if (i == 4) begin
        checks++;
        if ({busy, query_feature} !== {1'b0, 12'h000}) begin
          fails++;
          $display("FAIL gaps_not_primed: got busy=%b qf=%h want 0 000", busy, query_feature);
        end
      end
    end
    feat_valid = 1'b0;
    checks++;
    if ({busy, query_feature, rom_addr, train_valid} !== {1'b1, 12'h321, 10'd0, 1'b0}) begin
      fails++;
      $display("FAIL gaps_prime: got busy=%b qf=%h addr=%0d tv=%b want 1 321 0 0",
               busy, query_feature, rom_addr, train_valid);
    end
    wait_result(k);
    checks++;
    if ({k, result} !== {32'd7, 1'b1}) begin
      fails++;
      $display("FAIL gaps_result: got k=%0d res=%b want 7 1", k, result);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int k;
    core_result = 1'b1;
    send_query(4'h4, 4'h5, 4'h6);
    tick; tick;
    checks++;
    if ({rom_addr, train_valid} !== {10'd2, 1'b1}) begin
      fails++;
      $display("FAIL mid_stream_point: got addr=%0d tv=%b want 2 1", rom_addr, train_valid);
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++;
    if ({core_en, train_valid, result, feat_ready, busy, query_feature, result_valid}
        !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset: got en=%b tv=%b res=%b rdy=%b busy=%b qf=%h rv=%b want 0 0 0 1 0 000 0",
               core_en, train_valid, result, feat_ready, busy, query_feature, result_valid);
    end
    send_query(4'h4, 4'h5, 4'h6);
    checks++;
    if (query_feature !== 12'h654) begin
      fails++;
      $display("FAIL fresh_query: got %h want 654", query_feature);
    end
    wait_result(k);
    checks++;
    if ({k, result} !== {32'd7, 1'b1}) begin
      fails++;
      $display("FAIL fresh_result: got k=%0d res=%b want 7 1", k, result);
    end
    tick;
  endtask

`ifdef KNN_QSEQ_QCOUNT_EN
  task automatic test_qcount;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++;
    if (query_count !== 16'd0) begin
      fails++;
      $display("FAIL qcount_reset: got %0d want 0", query_count);
    end
    for (int q = 1; q <= 3; q++) begin
      send_query(4'h1, 4'h2, 4'h3);
      repeat (6) tick;
      checks++;
      if ({result_valid, query_count} !== {1'b0, 16'(q - 1)}) begin
        fails++;
        $display("FAIL qcount_before_%0d: got rv=%b cnt=%0d want 0 %0d", q, result_valid, query_count, q - 1);
      end
      tick;
      checks++;
      if ({result_valid, query_count} !== {1'b1, 16'(q)}) begin
        fails++;
        $display("FAIL qcount_at_%0d: got rv=%b cnt=%0d want 1 %0d", q, result_valid, query_count, q);
      end
      tick;
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    feat_valid = 1'b0;
    feat_in = 4'h0;
    core_result = 1'b0;
    test_reset;
    test_back_to_back;
    test_hold_valid;
    test_gaps;
    test_reset_mid;
`ifdef KNN_QSEQ_QCOUNT_EN
    test_qcount;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
